// File: rtl/ovl_win_change_multi_pkg.sv
// Shared types for the multi-channel window-change checker: fire codes,
// per-channel window states and a popcount helper for the violation counter.
package ovl_win_change_multi_pkg;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        NOCHANGE = 2'b01,
        CHANGED  = 2'b10,
        TIMEOUT  = 2'b11
    } fire_code_t;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } win_state_t;

    // Wide enough to count up to 32 simultaneous fires.
    localparam int POP_W = 6;

    function automatic logic [POP_W-1:0] popcount32(input logic [31:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/ovl_win_change_multi_if.sv
// Bus bundle between a stimulus source (master) and the window-change
// checker (slave): enables, window events, sampled data and results.
interface ovl_win_change_multi_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 1,
    parameter int CNT_W  = 16
);
    logic                      enable;
    logic [NUM_CH-1:0]         start_event;
    logic [NUM_CH-1:0]         end_event;
    logic [NUM_CH*WIDTH-1:0]   test_expr;
    logic [NUM_CH-1:0]         fire;
    logic [2*NUM_CH-1:0]       fire_code;
    logic [NUM_CH-1:0]         win_active;
    logic [CNT_W-1:0]          fire_count;

    modport master (
        output enable, start_event, end_event, test_expr,
        input  fire, fire_code, win_active, fire_count
    );

    modport slave (
        input  enable, start_event, end_event, test_expr,
        output fire, fire_code, win_active, fire_count
    );
endinterface

// File: rtl/ovl_win_change_ch.sv
// One checker channel: IDLE/OPEN window FSM with captured reference value,
// changed flag, window-length counter and a registered one-cycle fire.
module ovl_win_change_ch
    import ovl_win_change_multi_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int MODE    = 0,
    parameter int MAX_WIN = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             start_event,
    input  logic             end_event,
    input  logic [WIDTH-1:0] test_expr,
    output logic             fire_next,
    output logic             fire,
    output fire_code_t       fire_code,
    output logic             win_active
);
    localparam int            CW    = (MAX_WIN > 0) ? $clog2(MAX_WIN + 1) : 1;
    localparam logic [CW-1:0] MAX_V = CW'(MAX_WIN);

    win_state_t       state;
    logic [WIDTH-1:0] ref_val;
    logic             changed;
    logic [CW-1:0]    win_cnt;
    fire_code_t       code_next;
    logic             mismatch;
    logic             timeout_hit;

    assign mismatch    = (test_expr != ref_val);
    // An end_event on the MAX_WIN edge closes the window normally.
    assign timeout_hit = (MAX_WIN > 0) && (win_cnt == MAX_V) && !end_event;
    assign fire_next   = (code_next != NONE);
    assign win_active  = (state == OPEN);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        code_next = NONE;
        if (enable && state == OPEN) begin
            if (timeout_hit) begin
                code_next = TIMEOUT;
            end else if (MODE != 0 && mismatch && !changed) begin
                code_next = CHANGED;
            end else if (MODE == 0 && end_event && !changed && !mismatch) begin
                code_next = NOCHANGE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ref_val   <= '0;
            changed   <= 1'b0;
            win_cnt   <= '0;
            fire      <= 1'b0;
            fire_code <= NONE;
        end else begin
            fire      <= fire_next;
            fire_code <= code_next;
            if (!enable) begin
                state <= IDLE;
            end else if (state == IDLE) begin
                if (start_event) begin
                    state   <= OPEN;
                    ref_val <= test_expr;
                    changed <= 1'b0;
                    win_cnt <= CW'(1);
                end
            end else begin
                // In unchange mode the changed flag also marks "CHANGED already fired".
                if (mismatch) changed <= 1'b1;
                win_cnt <= win_cnt + 1'b1;
                if (end_event || timeout_hit) state <= IDLE;
            end
        end
    end

endmodule

// File: rtl/ovl_win_change_multi.sv
// Multi-channel window-change checker: NUM_CH independent channels plus a
// saturating count of all violations.
module ovl_win_change_multi
    import ovl_win_change_multi_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 1,
    parameter int MODE    = 0,
    parameter int MAX_WIN = 0,
    parameter int CNT_W   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    ovl_win_change_multi_if.slave  bus
);
    localparam int SUM_W = CNT_W + POP_W;

    logic [NUM_CH-1:0]   fire_next;
    logic [NUM_CH-1:0]   fire;
    logic [NUM_CH-1:0]   win_active;
    fire_code_t          codes [NUM_CH];
    logic [2*NUM_CH-1:0] code_vec;
    logic [CNT_W-1:0]    fire_count;
    logic [SUM_W-1:0]    sum;
    logic [CNT_W-1:0]    count_next;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ovl_win_change_ch #(
            .WIDTH  (WIDTH),
            .MODE   (MODE),
            .MAX_WIN(MAX_WIN)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .enable     (bus.enable),
            .start_event(bus.start_event[c]),
            .end_event  (bus.end_event[c]),
            .test_expr  (bus.test_expr[c*WIDTH +: WIDTH]),
            .fire_next  (fire_next[c]),
            .fire       (fire[c]),
            .fire_code  (codes[c]),
            .win_active (win_active[c])
        );
    end

    always_comb begin
        code_vec = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            code_vec[2*c +: 2] = codes[c];
        end
    end

    // Count the fires being registered this edge so fire_count moves with fire.
    always_comb begin
        sum        = SUM_W'(fire_count) + SUM_W'(popcount32(32'(fire_next)));
        count_next = (sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fire_count <= '0;
        end else begin
            fire_count <= count_next;
        end
    end

    assign bus.fire       = fire;
    assign bus.fire_code  = code_vec;
    assign bus.win_active = win_active;
    assign bus.fire_count = fire_count;

endmodule

// File: doc/ovl_win_change_multi.md
# ovl_win_change_multi

Multi-channel, parametrised window-change checker for the OVL-style assertion library used by the ivl_uvm test benches. Each channel opens a window on `start_event`, closes it on `end_event`, and checks one of two properties on its `test_expr` slice while the window is open:
- Change mode: the value must change before the window closes.
- Unchange mode: the value must hold for the whole window.

This block adds a maximum-window timeout, per-channel fire codes and a saturating violation counter, none of which the single-channel checker has.

## Interface
- `NUM_CH`, default 4: number of independent channels, 1..32.
- `WIDTH`, default 1: bits of `test_expr` per channel.
- `MODE`, default 0: 0 = must-change, 1 = must-not-change.
- `MAX_WIN`, default 0: maximum open-window length in cycles; 0 disables the timeout.
- `CNT_W`, default 16: width of `fire_count`.
- `clock`, input, 1: sole clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: global checker enable.
- `start_event`, input, NUM_CH: per-channel window open.
- `end_event`, input, NUM_CH: per-channel window close.
- `test_expr`, input, NUM_CH*WIDTH: channel c is `[c*WIDTH +: WIDTH]`.
- `fire`, output, NUM_CH: one-cycle violation pulse per channel.
- `fire_code`, output, 2*NUM_CH: channel c is `[2c+1:2c]`. Values: 00 none, 01 NOCHANGE, 10 CHANGED, 11 TIMEOUT.
- `win_active`, output, NUM_CH: channel window currently open.
- `fire_count`, output, CNT_W: total violations, saturating.

## Operation
- Each channel runs a two-state FSM: IDLE and OPEN.
- **IDLE → OPEN**
  - Taken when `start_event[c]` is sampled 1.
  - Captures `test_expr` slice into `ref_val`, clears the changed flag and sets the window counter to 1.
  - `end_event` sampled on the same edge is ignored; a window lasts at least one cycle.
- **OPEN, every edge**
  - If the slice differs from `ref_val`, set the changed flag. A difference on the edge where `end_event` is sampled also counts.
  - `start_event` is ignored while OPEN; it does not restart the window.
- **Unchange mode (`MODE`=1)**
  - The first mismatch in a window fires CHANGED.
  - The window stays OPEN until `end_event` or timeout.
  - At most one CHANGED fire per window.
- **OPEN → IDLE on `end_event[c]`**
  - Change mode (`MODE`=0): if the changed flag, including the current edge, is still clear, fire NOCHANGE.
  - Unchange mode: a mismatch on this same edge fires CHANGED, unless CHANGED already fired in this window.
- **Timeout** (`MAX_WIN`>0)
  - If the counter equals `MAX_WIN` and `end_event` is not sampled 1, fire TIMEOUT and go to IDLE. This takes priority over NOCHANGE.
  - If `end_event` arrives on the `MAX_WIN` edge, it closes normally with no TIMEOUT.
- **Single fire per edge**: each channel fires at most one code per edge. Priority is TIMEOUT > CHANGED > NOCHANGE.
- **`enable` = 0**: all channels are forced to IDLE, `fire` is 0, and no captures are taken.
- **`fire_count`**
  - Each cycle it adds the popcount of the next-state `fire` vector.
  - It saturates at all-ones and never wraps.

## Timing
- Reset values: all FSMs IDLE; `fire`, `fire_code`, `win_active` and `fire_count` all 0.
- Asserting `reset` mid-window discards the window silently; no fire is generated.
- `fire` and `fire_code` are registered:
  - They are asserted in the cycle after the violating edge and held for exactly one cycle.
  - `fire_code` reads 00 whenever `fire` is 0.
- `win_active` is high from the cycle after the opening edge through the closing edge.
- `fire_count` updates in the same cycle `fire` asserts.
- Back-to-back windows are allowed: `start_event` sampled on the edge after the close reopens the window.
- Channels are fully independent. Simultaneous fires on several channels all count.

## Structure
- Shared package `ovl_win_change_multi_pkg` holds:
  - the `fire_code_t` enum (NONE, NOCHANGE, CHANGED, TIMEOUT);
  - the `win_state_t` enum (IDLE, OPEN).
- Sub-module `ovl_win_change_ch` contains one channel's FSM, `ref_val`, changed flag, counter and registered fire. The top generates `NUM_CH` instances of it and owns the saturating `fire_count` adder.

## Test plan
- **Change mode, no change**: `MODE`=0, ch0 start with data 0, end next cycle with data 0 → `fire[0]`=1 with code 01 one cycle later; `fire_count`=1.
- **Change mode, change**: ch0 start with data 1, end with data 0 → no fire; `win_active[0]` high for 1 cycle.
- **Unchange mode, mismatch**: `MODE`=1, `WIDTH`=8. Open with 8'hA5, drive 8'h5A for 2 cycles, then end → exactly one CHANGED fire on the first mismatch.
- **Timeout**: `MAX_WIN`=3, start and never end → TIMEOUT on the third window edge, `win_active` drops. A second start on the next edge reopens.
- **Simultaneous and saturation**: `CNT_W`=2, 4 channels violate on the same edge → `fire`=4'hF, `fire_count` saturates at 3 and stays there on further fires.
- **Reset and enable**: async `reset` low mid-window → outputs 0 immediately, no fire. `enable` low mid-window → IDLE, no fire. Re-enable and start → normal checking resumes.
